// File: rtl/trace_pkg.sv
// Shared types and default sizes for the trace capture controller.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3,
    READ  = 3'd4
  } trace_state_t;

  localparam int TRACE_WIDTH = 48;
  localparam int TRACE_DEPTH = 1024;

  // Saturating increment for the 16-bit drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trace_read_stage.sv
// Readout engine: issues one BRAM read at a time (oldest-first, wrapping),
// tracks the single in-flight read and holds the returned sample in a
// one-entry output slot exposed as first/deq.
module trace_read_stage
  import trace_pkg::*;
#(
  parameter int width = TRACE_WIDTH,
  parameter int depth = TRACE_DEPTH,
  localparam int AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             active,
  input  logic             load,
  input  logic [AW-1:0]    load_addr,
  input  logic [AW:0]      load_len,
  input  logic             rd_rdy,
  input  logic [width-1:0] rd_data,
  output logic             rd_ena,
  output logic [AW-1:0]    rd_addr,
  input  logic             deq,
  output logic [width-1:0] first,
  output logic             first_rdy,
  output logic             busy
);

  logic [AW-1:0]    rdptr_q, rdptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             inflight_q, inflight_d;
  logic             slot_vld_q, slot_vld_d;
  logic [width-1:0] slot_data_q, slot_data_d;
  logic             deq_ok;
  logic             issue;

  // Read issue, pointer/remaining bookkeeping and output slot update.
  always_comb begin
    deq_ok      = deq && slot_vld_q;
    issue       = active && !flush && rd_rdy && (rem_q != '0) && !inflight_q &&
                  (!slot_vld_q || deq_ok);
    rdptr_d     = rdptr_q;
    rem_d       = rem_q;
    inflight_d  = issue;
    slot_vld_d  = slot_vld_q;
    slot_data_d = slot_data_q;
    if (load) begin
      rdptr_d = load_addr;
      rem_d   = load_len;
    end else if (issue) begin
      rdptr_d = rdptr_q + AW'(1);
      rem_d   = rem_q - 1'b1;
    end
    if (deq_ok) slot_vld_d = 1'b0;
    // Data returns one cycle after the read was accepted.
    if (inflight_q) begin
      slot_vld_d  = 1'b1;
      slot_data_d = rd_data;
    end
    // Abort discards the slot and any read still in flight.
    if (flush) begin
      slot_vld_d = 1'b0;
      inflight_d = 1'b0;
      rem_d      = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr_q    <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      slot_vld_q <= 1'b0;
    end else begin
      rdptr_q    <= rdptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  // Slot payload; qualified by slot_vld_q so it needs no reset.
  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
  end

  assign rd_ena    = issue;
  assign rd_addr   = rdptr_q;
  assign first     = slot_data_q;
  assign first_rdy = slot_vld_q;
  assign busy      = (rem_q != '0) || inflight_q || slot_vld_q;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace buffer sequencer: circular capture, post-trigger countdown, freeze,
// then oldest-first readout through trace_read_stage.
// Optional macro TRACE_DROP_CNT_EN adds a saturating 16-bit `drops` output
// counting samples lost while the BRAM write port was not ready.
module trace_capture_ctrl
  import trace_pkg::*;
#(
  parameter int width = TRACE_WIDTH,
  parameter int depth = TRACE_DEPTH,
  localparam int AW = $clog2(depth)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             arm__ENA,
  input  logic [AW:0]      arm_post,
  output logic             arm__RDY,
  input  logic             abort__ENA,
  input  logic             enable,
  input  logic             trigger,
  input  logic [width-1:0] data,
  output logic             bram_write__ENA,
  output logic [AW-1:0]    bram_write_addr,
  output logic [width-1:0] bram_write_data,
  input  logic             bram_write__RDY,
  output logic             bram_read__ENA,
  output logic [AW-1:0]    bram_read_addr,
  input  logic             bram_read__RDY,
  input  logic [width-1:0] bram_dataOut,
  output logic [width-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             out_deq__ENA,
`ifdef TRACE_DROP_CNT_EN
  output logic [15:0]      drops,
`endif
  output logic [2:0]       state,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   post_q, post_d;
  logic [AW:0]   rem_q, rem_d;
  logic          capturing;
  logic          wr_fire;
  logic          arm_go;
  logic          rd_load;
  logic          rd_busy;
  logic [AW-1:0] rd_start;

  assign capturing = (state_q == ARMED) || (state_q == POST);
  assign wr_fire   = enable && bram_write__RDY && capturing;
  assign arm__RDY  = (state_q == IDLE) || (state_q == DONE);
  assign arm_go    = arm__ENA && arm__RDY;
  // A full buffer has wrapped, so the oldest sample sits at the write pointer.
  assign rd_start  = (count_q == DEPTH_C) ? wptr_q : '0;

  // Next-state logic for the sequencer and the write path.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    post_d  = post_q;
    rem_d   = rem_q;
    rd_load = 1'b0;
    if (wr_fire) begin
      wptr_d = wptr_q + AW'(1);
      if (count_q != DEPTH_C) count_d = count_q + 1'b1;
    end
    case (state_q)
      IDLE:  ;
      ARMED: begin
        if (trigger) begin
          if (post_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = POST;
            rem_d   = post_q;
          end
        end
      end
      POST: begin
        if (wr_fire) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == ONE_C) state_d = DONE;
        end
      end
      DONE: begin
        if (count_q != '0) begin
          rd_load = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (!rd_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Arming is only accepted in IDLE/DONE and wins over the DONE->READ move.
    if (arm_go) begin
      wptr_d  = '0;
      count_d = '0;
      post_d  = arm_post;
      rd_load = 1'b0;
      state_d = ARMED;
    end
    // Abort beats everything else.
    if (abort__ENA) begin
      count_d = '0;
      rd_load = 1'b0;
      state_d = IDLE;
    end
  end

  // Sequencer and write-path registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      post_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      post_q  <= post_d;
      rem_q   <= rem_d;
    end
  end

  trace_read_stage #(
    .width (width),
    .depth (depth)
  ) u_read (
    .clk       (CLK),
    .rst       (RST),
    .flush     (abort__ENA),
    .active    (state_q == READ),
    .load      (rd_load),
    .load_addr (rd_start),
    .load_len  (count_q),
    .rd_rdy    (bram_read__RDY),
    .rd_data   (bram_dataOut),
    .rd_ena    (bram_read__ENA),
    .rd_addr   (bram_read_addr),
    .deq       (out_deq__ENA),
    .first     (out_first),
    .first_rdy (out_first__RDY),
    .busy      (rd_busy)
  );

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drops_q, drops_d;

  // Count samples lost to a busy BRAM write port during capture.
  always_comb begin
    drops_d = drops_q;
    if (capturing && enable && !bram_write__RDY) drops_d = sat_inc16(drops_q);
    if (arm_go || abort__ENA) drops_d = '0;
  end

  // Drop counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) drops_q <= '0;
    else     drops_q <= drops_d;
  end

  assign drops = drops_q;
`endif

  assign bram_write__ENA = wr_fire;
  assign bram_write_addr = wptr_q;
  assign bram_write_data = data;
  assign state           = state_q;
  assign count           = count_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl (depth 16, 16-bit samples) with a BRAM model
// and a scoreboard of expected readout samples.
module tb_trace_capture_ctrl;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_ena;
  logic [AW:0]   arm_post;
  logic          arm_rdy;
  logic          abort_ena;
  logic          enable;
  logic          trigger;
  logic [W-1:0]  data;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_rdy;
  logic          rd_ena;
  logic [AW-1:0] rd_addr;
  logic          rd_rdy;
  logic [W-1:0]  rd_dout;
  logic [W-1:0]  out_first;
  logic          out_first_rdy;
  logic          out_deq;
  logic [2:0]    state;
  logic [AW:0]   count;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0]   drops;
`endif

  int           checks = 0;
  int           failures = 0;
  int           rd_issued = 0;
  logic         consume_en;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mem [D];

  always #5 clk = ~clk;

  trace_capture_ctrl #(.width(W), .depth(D)) dut (
    .CLK             (clk),
    .RST             (rst),
    .arm__ENA        (arm_ena),
    .arm_post        (arm_post),
    .arm__RDY        (arm_rdy),
    .abort__ENA      (abort_ena),
    .enable          (enable),
    .trigger         (trigger),
    .data            (data),
    .bram_write__ENA (wr_ena),
    .bram_write_addr (wr_addr),
    .bram_write_data (wr_data),
    .bram_write__RDY (wr_rdy),
    .bram_read__ENA  (rd_ena),
    .bram_read_addr  (rd_addr),
    .bram_read__RDY  (rd_rdy),
    .bram_dataOut    (rd_dout),
    .out_first       (out_first),
    .out_first__RDY  (out_first_rdy),
    .out_deq__ENA    (out_deq),
`ifdef TRACE_DROP_CNT_EN
    .drops           (drops),
`endif
    .state           (state),
    .count           (count)
  );

  // BRAM model: synchronous write, read data one cycle after the read.
  always @(posedge clk) begin
    if (wr_ena) mem[wr_addr] <= wr_data;
    if (rd_ena) begin
      rd_dout   <= mem[rd_addr];
      rd_issued <= rd_issued + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Consumer + scoreboard monitor: pops whenever a sample is dequeued.
  always @(negedge clk) begin
    if (!rst && consume_en && out_first_rdy) begin
      out_deq = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL readout_unexpected actual=%0h required=none", out_first);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("readout", out_first, mon_exp);
      end
    end else begin
      out_deq = 1'b0;
    end
  end

  task automatic step(input logic en, input logic tr, input logic [W-1:0] d, input logic wrdy);
    @(negedge clk);
    enable  = en;
    trigger = tr;
    data    = d;
    wr_rdy  = wrdy;
  endtask

  task automatic settle();
    @(negedge clk);
    enable  = 1'b0;
    trigger = 1'b0;
    wr_rdy  = 1'b1;
  endtask

  task automatic arm(input logic [AW:0] p);
    @(negedge clk);
    arm_ena  = 1'b1;
    arm_post = p;
    @(negedge clk);
    arm_ena  = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(state == 3'd0 && exp_q.size() == 0 && !out_first_rdy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int issued;
    rst = 1'b1; arm_ena = 1'b0; arm_post = '0; abort_ena = 1'b0;
    enable = 1'b0; trigger = 1'b0; data = '0; wr_rdy = 1'b1; rd_rdy = 1'b1;
    out_deq = 1'b0; consume_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_arm_rdy", arm_rdy, 1);
    chk("rst_count", count, 0);
    chk("rst_first_rdy", out_first_rdy, 0);
    chk("rst_wr_ena", wr_ena, 0);
    chk("rst_rd_ena", rd_ena, 0);
    rst = 1'b0;

    // Post=4, trigger on sample 3: samples 1..7 captured.
    arm(5'd4);
    chk("t1_armed", state, 1);
    chk("t1_arm_rdy", arm_rdy, 0);
    for (int i = 1; i <= 7; i++) exp_q.push_back(W'(i));
    for (int i = 1; i <= 7; i++) step(1'b1, (i == 3), W'(i), 1'b1);
    settle();
    chk("t1_done", state, 3);
    chk("t1_count", count, 7);
    wait_idle("t1_idle", 200);

    // Wrap: 40 samples, trigger at 30, post=5 -> 20..35.
    arm(5'd5);
    for (int i = 20; i <= 35; i++) exp_q.push_back(W'(i));
    for (int i = 0; i < 40; i++) step(1'b1, (i == 30), W'(i), 1'b1);
    settle();
    chk("t2_count_sat", count, 16);
    wait_idle("t2_idle", 300);

    // Post=0: trigger sample is last.
    arm(5'd0);
    for (int i = 5; i <= 9; i++) exp_q.push_back(W'(i));
    for (int i = 5; i <= 9; i++) step(1'b1, (i == 9), W'(i), 1'b1);
    settle();
    chk("t3_done", state, 3);
    wait_idle("t3_idle", 200);

    // Write port not ready for samples 3..5: they are dropped.
    arm(5'd2);
    exp_q.push_back(16'd1); exp_q.push_back(16'd2); exp_q.push_back(16'd6);
    exp_q.push_back(16'd7); exp_q.push_back(16'd8); exp_q.push_back(16'd9);
    step(1'b1, 1'b0, 16'd1, 1'b1);
    step(1'b1, 1'b0, 16'd2, 1'b1);
    step(1'b1, 1'b0, 16'd3, 1'b0);
    #1 chk("t4_no_write", wr_ena, 0);
    step(1'b1, 1'b0, 16'd4, 1'b0);
    step(1'b1, 1'b0, 16'd5, 1'b0);
    step(1'b1, 1'b0, 16'd6, 1'b1);
    step(1'b1, 1'b1, 16'd7, 1'b1);
    step(1'b1, 1'b0, 16'd8, 1'b1);
    step(1'b1, 1'b0, 16'd9, 1'b1);
    settle();
    chk("t4_done", state, 3);
    chk("t4_count", count, 6);
`ifdef TRACE_DROP_CNT_EN
    chk("t4_drops", drops, 3);
`endif
    wait_idle("t4_idle", 200);

    // Consumer stalls 10 cycles: head stable, no extra reads.
    consume_en = 1'b0;
    arm(5'd1);
`ifdef TRACE_DROP_CNT_EN
    chk("t5_drops_cleared", drops, 0);
`endif
    for (int i = 1; i <= 4; i++) exp_q.push_back(W'(i));
    for (int i = 1; i <= 4; i++) step(1'b1, (i == 3), W'(i), 1'b1);
    settle();
    n = 0;
    while (!out_first_rdy && n < 20) begin @(negedge clk); n++; end
    chk("t5_first_seen", out_first_rdy, 1);
    issued = rd_issued;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_rdy", out_first_rdy, 1);
      chk("t5_hold_val", out_first, 1);
    end
    chk("t5_no_extra_rd", rd_issued, issued);
    consume_en = 1'b1;
    wait_idle("t5_idle", 200);

    // Abort with a read in flight.
    consume_en = 1'b0;
    arm(5'd1);
    for (int i = 1; i <= 4; i++) step(1'b1, (i == 3), W'(i), 1'b1);
    settle();
    n = 0;
    while (!rd_ena && n < 20) begin @(negedge clk); n++; end
    chk("t6_rd_seen", rd_ena, 1);
    @(negedge clk);
    abort_ena = 1'b1;
    @(negedge clk);
    abort_ena = 1'b0;
    chk("t6_state", state, 0);
    chk("t6_first_rdy", out_first_rdy, 0);
    chk("t6_count", count, 0);
    @(negedge clk);
    chk("t6_discarded", out_first_rdy, 0);
    consume_en = 1'b1;
    arm(5'd0);
    exp_q.push_back(16'd10); exp_q.push_back(16'd11);
    step(1'b1, 1'b0, 16'd10, 1'b1);
    step(1'b1, 1'b1, 16'd11, 1'b1);
    settle();
    chk("t6_rearm_count", count, 2);
    wait_idle("t6_idle", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
